// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register file slave.
//   resp_t     : AXI response codes
//   wr_state_t : write channel FSM states
//   rd_state_t : read channel FSM states
//   addr_lsb() : byte-offset bits ignored when decoding a register index
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_WAIT_W,
      WR_WAIT_AW,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_t;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axi_lite_reg_array.sv
// Register storage for the AXI4-Lite slave: one byte-strobed write port,
// all registers read out in parallel.
//   clk, rst  : clock, synchronous active-high reset (loads RESET_VAL)
//   wr_en     : commit the write port this cycle
//   wr_idx    : register index (may be out of range)
//   wr_data   : write data
//   wr_strb   : byte enables, byte k replaced where wr_strb[k]=1
//   wr_ok     : wr_idx names an existing, bus-writable register
//   regs      : flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse  : bit i high for the cycle after register i was committed
module axi_lite_reg_array
   import axi_lite_pkg::*;
#(
   parameter int                             DATA_WIDTH = 32,
   parameter int                             NUM_REGS   = 16,
   parameter int                             IDX_W      = 10,
   parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [IDX_W-1:0]                 wr_idx,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/8-1:0]          wr_strb,
   output logic                             wr_ok,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   regs,
   output logic [NUM_REGS-1:0]              wr_pulse
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];
   logic [NUM_REGS-1:0]   hit;

   // One-hot decode that already excludes read-only and out-of-range indices,
   // so a zero vector means the write must be rejected.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_idx == IDX_W'(i) && !RO_MASK[i]) hit[i] = 1'b1;
      end
   end

   assign wr_ok = |hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
         wr_pulse <= '0;
      end else begin
         // Pulse fires even with an all-zero strobe: the write was accepted.
         wr_pulse <= wr_en ? hit : '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int k = 0; k < NB; k++) begin
               if (wr_en && hit[i] && wr_strb[k]) mem[i][k*8 +: 8] <= wr_data[k*8 +: 8];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign regs[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
   end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave in front of a parametrised register file. Write and read
// channels run independently; AW and W may arrive in either order.
//   clk, rst                 : clock, synchronous active-high reset
//   aw*/w*/b*                : AXI4-Lite write address, data, response
//   ar*/r*                   : AXI4-Lite read address, data
//   regs_o                   : all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_o               : bit i high on the cycle register i is updated
//
// state       | meaning
// WR_IDLE     | ready for AW and W
// WR_WAIT_W   | address held, waiting for data
// WR_WAIT_AW  | data/strobes held, waiting for address
// WR_RESP     | write committed; bvalid raised next cycle, held until bready
// RD_IDLE     | ready for AR
// RD_DATA     | rdata/rresp held until rready
module axi_lite_regfile_slave
   import axi_lite_pkg::*;
#(
   parameter int                             DATA_WIDTH = 32,
   parameter int                             ADDR_WIDTH = 12,
   parameter int                             NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
   localparam int STRB_W   = DATA_WIDTH / 8;

   wr_state_t             wr_state;
   rd_state_t             rd_state;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;

   logic                  aw_hs, w_hs;
   logic                  wr_en, wr_ok;
   logic [IDX_W-1:0]      wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   resp_t                 wr_resp;

   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_hit;
   logic [DATA_WIDTH-1:0] rd_val;

   logic                  unused_addr_lsbs;
   assign unused_addr_lsbs = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // Write port mux: whichever half arrived earlier comes from its latch,
   // the half completing now comes straight from the bus.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = awaddr[ADDR_WIDTH-1:ADDR_LSB];
      wr_data = wdata;
      wr_strb = wstrb;
      case (wr_state)
         WR_IDLE:    wr_en = aw_hs && w_hs;
         WR_WAIT_W: begin
            wr_en  = w_hs;
            wr_idx = aw_idx_q;
         end
         WR_WAIT_AW: begin
            wr_en   = aw_hs;
            wr_data = wdata_q;
            wr_strb = wstrb_q;
         end
         default:    wr_en = 1'b0;
      endcase
   end

   assign wr_resp = wr_ok ? OKAY : SLVERR;

   axi_lite_reg_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W),
      .RO_MASK    (RO_MASK),
      .RESET_VAL  (RESET_VAL)
   ) u_reg_array (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb),
      .wr_ok    (wr_ok),
      .regs     (regs_o),
      .wr_pulse (wr_pulse_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_IDLE;
         awready  <= 1'b1;
         wready   <= 1'b1;
         bvalid   <= 1'b0;
         bresp    <= OKAY;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (aw_hs && w_hs) begin
                  awready  <= 1'b0;
                  wready   <= 1'b0;
                  bresp    <= wr_resp;
                  wr_state <= WR_RESP;
               end else if (aw_hs) begin
                  aw_idx_q <= awaddr[ADDR_WIDTH-1:ADDR_LSB];
                  awready  <= 1'b0;
                  wr_state <= WR_WAIT_W;
               end else if (w_hs) begin
                  wdata_q  <= wdata;
                  wstrb_q  <= wstrb;
                  wready   <= 1'b0;
                  wr_state <= WR_WAIT_AW;
               end
            end
            WR_WAIT_W: begin
               if (w_hs) begin
                  wready   <= 1'b0;
                  bresp    <= wr_resp;
                  wr_state <= WR_RESP;
               end
            end
            WR_WAIT_AW: begin
               if (aw_hs) begin
                  awready  <= 1'b0;
                  bresp    <= wr_resp;
                  wr_state <= WR_RESP;
               end
            end
            WR_RESP: begin
               // First cycle here is the commit-pulse cycle; bvalid follows.
               if (!bvalid) begin
                  bvalid <= 1'b1;
               end else if (bready) begin
                  bvalid   <= 1'b0;
                  awready  <= 1'b1;
                  wready   <= 1'b1;
                  wr_state <= WR_IDLE;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   assign rd_idx = araddr[ADDR_WIDTH-1:ADDR_LSB];

   always_comb begin
      rd_hit = 1'b0;
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_hit = 1'b1;
            rd_val = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Captures the pre-edge register value, so a read accepted on a commit
   // edge returns the old contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= RD_IDLE;
         arready  <= 1'b1;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rresp    <= OKAY;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (arvalid && arready) begin
                  rdata    <= rd_hit ? rd_val : '0;
                  rresp    <= rd_hit ? OKAY : SLVERR;
                  rvalid   <= 1'b1;
                  arready  <= 1'b0;
                  rd_state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid && rready) begin
                  rvalid   <= 1'b0;
                  arready  <= 1'b1;
                  rd_state <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Self-checking bench for axi_lite_regfile_slave: hand-written corner
// sequences, a table of directed transactions and a randomized phase
// checked against an array-based register model.
module tb_axi_lite_regfile_slave;
   import axi_lite_pkg::*;

   localparam int DW  = 32;
   localparam int AW  = 12;
   localparam int NR  = 16;
   localparam int TMO = 50;
   localparam logic [NR-1:0]    RO = 16'h0008;
   localparam logic [NR*DW-1:0] RV = {{(NR*DW-4*DW){1'b0}}, 32'hCAFE0001, 96'h0};

   logic             clk, rst;
   logic [AW-1:0]    awaddr, araddr;
   logic             awvalid, awready, wvalid, wready, bvalid, bready;
   logic [DW-1:0]    wdata, rdata;
   logic [DW/8-1:0]  wstrb;
   logic [1:0]       bresp, rresp;
   logic             arvalid, arready, rvalid, rready;
   logic [NR*DW-1:0] regs_o;
   logic [NR-1:0]    wr_pulse_o;

   axi_lite_regfile_slave #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_REGS (NR),
      .RO_MASK (RO), .RESET_VAL (RV)
   ) dut (
      .clk (clk), .rst (rst),
      .awaddr (awaddr), .awvalid (awvalid), .awready (awready),
      .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
      .bresp (bresp), .bvalid (bvalid), .bready (bready),
      .araddr (araddr), .arvalid (arvalid), .arready (arready),
      .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready),
      .regs_o (regs_o), .wr_pulse_o (wr_pulse_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int pulse_cnt [NR];
   logic [DW-1:0] mdl [NR];

   always @(negedge clk) begin
      for (int i = 0; i < NR; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: handshake timeout after %0d cycles", nm, TMO);
   endtask

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < NR; i++) mdl[i] = RV[i*DW +: DW];
   endfunction

   function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                              input logic [3:0] s, output logic [NR-1:0] pm);
      int idx;
      idx = int'(a) / 4;
      pm  = '0;
      if (idx >= NR || RO[idx]) return 2'b10;
      for (int k = 0; k < 4; k++) if (s[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
      pm[idx] = 1'b1;
      return 2'b00;
   endfunction

   function automatic logic [1:0] model_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      int idx;
      idx = int'(a) / 4;
      if (idx >= NR) begin
         d = '0;
         return 2'b10;
      end
      d = mdl[idx];
      return 2'b00;
   endfunction

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
      return f;
   endfunction

   // ---------------- bus tasks (entered and left at posedge+1) ----------------
   task automatic axi_write(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
      int snap [NR];
      int n, tot;
      logic [NR-1:0] mask;
      for (int i = 0; i < NR; i++) snap[i] = pulse_cnt[i];
      fork
         begin
            int na;
            repeat (aw_dly) @(posedge clk);
            #1 awaddr = a; awvalid = 1'b1;
            na = 0;
            @(negedge clk);
            while (!awready && na < TMO) begin na++; @(negedge clk); end
            if (!awready) tmo({nm, " aw"});
            @(posedge clk);
            #1 awvalid = 1'b0;
         end
         begin
            int nw;
            repeat (w_dly) @(posedge clk);
            #1 wdata = d; wstrb = s; wvalid = 1'b1;
            nw = 0;
            @(negedge clk);
            while (!wready && nw < TMO) begin nw++; @(negedge clk); end
            if (!wready) tmo({nm, " w"});
            @(posedge clk);
            #1 wvalid = 1'b0;
         end
      join
      n = 0;
      @(negedge clk);
      while (!bvalid && n < TMO) begin n++; @(negedge clk); end
      chk({nm, " bvalid"}, 512'(bvalid), 512'(1'b1));
      chk({nm, " bresp"}, 512'(bresp), 512'(exp_resp));
      repeat (b_dly) begin
         @(negedge clk);
         chk({nm, " bvalid_hold"}, 512'(bvalid), 512'(1'b1));
         chk({nm, " bresp_hold"}, 512'(bresp), 512'(exp_resp));
      end
      bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
      tot  = 0;
      mask = '0;
      for (int i = 0; i < NR; i++) begin
         mask[i] = (pulse_cnt[i] != snap[i]);
         tot += pulse_cnt[i] - snap[i];
      end
      chk({nm, " pulse_mask"}, 512'(mask), 512'(exp_pulse));
      chk({nm, " pulse_total"}, 512'(tot), 512'($countones(exp_pulse)));
   endtask

   task automatic axi_read(input string nm, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
      int n;
      araddr = a; arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < TMO) begin n++; @(negedge clk); end
      if (!arready) tmo({nm, " ar"});
      @(posedge clk);
      #1 arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rvalid && n < TMO) begin n++; @(negedge clk); end
      chk({nm, " rvalid"}, 512'(rvalid), 512'(1'b1));
      chk({nm, " rdata"}, 512'(rdata), 512'(exp_data));
      chk({nm, " rresp"}, 512'(rresp), 512'(exp_resp));
      rready = 1'b1;
      @(posedge clk);
      #1 rready = 1'b0;
   endtask

   typedef struct {
      logic            is_rd;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [3:0]      strb;
      int              aw_dly;
      int              w_dly;
      int              b_dly;
      logic [DW-1:0]   exp_data;
      logic [1:0]      exp_resp;
      logic [NR-1:0]   exp_pulse;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [1:0]    er;
      logic [NR-1:0] pm;
      logic [DW-1:0] ed, rd_d;
      logic [AW-1:0] ra;
      logic [3:0]    rs;
      int            n, idx, d1, d2, d3;

      tbl[0]  = '{1'b0, 12'h004, 32'hAABBCCDD, 4'b0101, 3, 0, 5, 32'h0,        2'b00, 16'h0002};
      tbl[1]  = '{1'b1, 12'h004, 32'h0,        4'b0000, 0, 0, 0, 32'h12BB56DD, 2'b00, 16'h0000};
      tbl[2]  = '{1'b0, 12'h00C, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 32'h0,        2'b10, 16'h0000};
      tbl[3]  = '{1'b1, 12'h00C, 32'h0,        4'b0000, 0, 0, 0, 32'hCAFE0001, 2'b00, 16'h0000};
      tbl[4]  = '{1'b0, 12'h040, 32'h11111111, 4'b1111, 0, 1, 0, 32'h0,        2'b10, 16'h0000};
      tbl[5]  = '{1'b1, 12'h040, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        2'b10, 16'h0000};
      tbl[6]  = '{1'b0, 12'h008, 32'hDEADBEEF, 4'b0000, 0, 2, 0, 32'h0,        2'b00, 16'h0004};
      tbl[7]  = '{1'b1, 12'h008, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        2'b00, 16'h0000};
      tbl[8]  = '{1'b0, 12'h03C, 32'hA5A5A5A5, 4'b1111, 1, 1, 2, 32'h0,        2'b00, 16'h8000};
      tbl[9]  = '{1'b1, 12'h03F, 32'h0,        4'b0000, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 16'h0000};
      tbl[10] = '{1'b0, 12'hFFC, 32'h00000001, 4'b1111, 0, 0, 0, 32'h0,        2'b10, 16'h0000};
      tbl[11] = '{1'b1, 12'hFFC, 32'h0,        4'b0000, 0, 0, 0, 32'h0,        2'b10, 16'h0000};

      rst = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst awready", 512'(awready), 512'(1'b1));
      chk("rst wready", 512'(wready), 512'(1'b1));
      chk("rst arready", 512'(arready), 512'(1'b1));
      chk("rst bvalid", 512'(bvalid), 512'(1'b0));
      chk("rst rvalid", 512'(rvalid), 512'(1'b0));
      chk("rst rdata", 512'(rdata), 512'(32'h0));
      chk("rst pulse", 512'(wr_pulse_o), 512'(16'h0));
      chk("rst regs", 512'(regs_o), 512'(RV));
      @(posedge clk);
      #1;
      axi_read("rd_reg3_reset", 12'h00C, 32'hCAFE0001, 2'b00);
      axi_read("rd_reg0_reset", 12'h000, 32'h0, 2'b00);

      // AW and W together: pulse on the cycle after the handshake, bvalid the next
      awaddr = 12'h004; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("t2 ready_both", 512'({awready, wready}), 512'(2'b11));
      @(posedge clk);
      #1 awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      chk("t2 pulse", 512'(wr_pulse_o), 512'(16'h0002));
      chk("t2 bvalid_early", 512'(bvalid), 512'(1'b0));
      chk("t2 regs1", 512'(regs_o[63:32]), 512'(32'h12345678));
      chk("t2 ready_busy", 512'({awready, wready}), 512'(2'b00));
      @(negedge clk);
      chk("t2 pulse_gone", 512'(wr_pulse_o), 512'(16'h0));
      chk("t2 bvalid", 512'(bvalid), 512'(1'b1));
      chk("t2 bresp", 512'(bresp), 512'(2'b00));
      bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
      @(negedge clk);
      chk("t2 idle_ready", 512'({awready, wready, bvalid}), 512'(3'b110));
      void'(model_write(12'h004, 32'h12345678, 4'hF, pm));
      @(posedge clk);
      #1;

      // directed table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].is_rd) begin
            axi_read($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp);
         end else begin
            axi_write($sformatf("tbl%0d_wr", i), tbl[i].addr, tbl[i].data, tbl[i].strb,
                      tbl[i].aw_dly, tbl[i].w_dly, tbl[i].b_dly, tbl[i].exp_resp, tbl[i].exp_pulse);
            void'(model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, pm));
         end
      end
      chk("tbl regs3", 512'(regs_o[127:96]), 512'(32'hCAFE0001));
      chk("tbl regs1", 512'(regs_o[63:32]), 512'(32'h12BB56DD));

      // read accepted on the same edge a write to the same register commits
      awaddr = 12'h004; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 12'h004; arvalid = 1'b1;
      @(negedge clk);
      chk("t5 ready_all", 512'({awready, wready, arready}), 512'(3'b111));
      @(posedge clk);
      #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk);
      chk("t5 rvalid", 512'(rvalid), 512'(1'b1));
      chk("t5 rdata_old", 512'(rdata), 512'(32'h12BB56DD));
      chk("t5 rresp", 512'(rresp), 512'(2'b00));
      rready = 1'b1;
      @(posedge clk);
      #1 rready = 1'b0;
      @(negedge clk);
      chk("t5 bvalid", 512'(bvalid), 512'(1'b1));
      chk("t5 bresp", 512'(bresp), 512'(2'b00));
      bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
      void'(model_write(12'h004, 32'h0, 4'hF, pm));
      axi_read("t5 rd_new", 12'h004, 32'h0, 2'b00);

      // reset while a write response is pending
      awaddr = 12'h014; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk);
      #1 awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bvalid && n < TMO) begin n++; @(negedge clk); end
      chk("t6 bvalid_pending", 512'(bvalid), 512'(1'b1));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6 bvalid", 512'(bvalid), 512'(1'b0));
      chk("t6 ready", 512'({awready, wready}), 512'(2'b11));
      chk("t6 regs", 512'(regs_o), 512'(RV));
      model_reset();

      // reset after only W was accepted: nothing may commit
      @(posedge clk);
      #1 wdata = 32'h5555; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk);
      #1 wvalid = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort ready", 512'({awready, wready, bvalid}), 512'(3'b110));
      chk("abort regs", 512'(regs_o), 512'(RV));
      @(posedge clk);
      #1;
      axi_write("abort_next_wr", 12'h008, 32'h00001234, 4'b0011, 0, 0, 0, 2'b00, 16'h0004);
      void'(model_write(12'h008, 32'h00001234, 4'b0011, pm));
      chk("abort_next regs", 512'(regs_o), 512'(model_flat()));

      // randomized traffic against the model
      for (int t = 0; t < 80; t++) begin
         idx = $urandom_range(0, 19);
         ra  = AW'(idx * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            ed = $urandom;
            rs = 4'($urandom_range(0, 15));
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            d3 = $urandom_range(0, 3);
            er = model_write(ra, ed, rs, pm);
            axi_write($sformatf("rnd%0d_wr", t), ra, ed, rs, d1, d2, d3, er, pm);
            chk($sformatf("rnd%0d_regs", t), 512'(regs_o), 512'(model_flat()));
         end else begin
            er = model_read(ra, rd_d);
            axi_read($sformatf("rnd%0d_rd", t), ra, rd_d, er);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
Parametrised AXI4-Lite slave with an internal register file. It generalises the existing fixed-width slave in data width, address width and register count. It adds byte strobes, out-of-range and read-only error responses, AW/W arrival in any order, and independent read/write channels. It sits behind any axi_lite_master as the control/status register block for a peripheral, and exposes every register in parallel to the surrounding logic.

Parameters:
- DATA_WIDTH, 32: AXI data width; 32 or 64 only.
- ADDR_WIDTH, 12: AXI address width.
- NUM_REGS, 16: number of DATA_WIDTH registers; 1..2**(ADDR_WIDTH-ADDR_LSB).
- RO_MASK, '0: NUM_REGS bits; bit i=1 makes register i read-only to the bus.
- RESET_VAL, '0: NUM_REGS*DATA_WIDTH flat vector of per-register reset values.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- regs_o  out  NUM_REGS*DATA_WIDTH  current register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse_o  out  NUM_REGS  one-cycle strobe, bit i high on the cycle register i is updated

Behaviour:
- Reset (clk edge with rst=1):
  - registers load RESET_VAL.
  - FSMs return to idle.
  - awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; wr_pulse_o=0.
  - Reset mid-transaction aborts it: no commit, no response.
- Addressing:
  - ADDR_LSB = log2(DATA_WIDTH/8).
  - index = addr[ADDR_WIDTH-1:ADDR_LSB]; low bits are ignored.
  - index >= NUM_REGS is out-of-range.
- Write FSM states: WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP.
  - WR_IDLE: awready=wready=1.
    - Both handshakes in the same cycle -> WR_RESP.
    - AW only -> latch address, go to WR_WAIT_W (awready=0, wready=1).
    - W only -> latch data and strobes, go to WR_WAIT_AW (wready=0, awready=1).
  - Commit happens on the transition into WR_RESP, one cycle after the final handshake.
    - Commit rule: byte k of the register is replaced where wstrb[k]=1.
    - wr_pulse_o[i] is high on that same cycle; bvalid=1 from the next cycle.
    - In WR_RESP, awready=wready=0.
  - Error cases:
    - Out-of-range or RO_MASK[i]=1 -> no update, no pulse, bresp=SLVERR(2'b10).
    - Otherwise bresp=OKAY(2'b00).
    - wstrb=0 on a valid writable register -> OKAY, no update, pulse still asserted.
  - WR_RESP holds bvalid and bresp stable until bready. On the bvalid&&bready cycle -> WR_IDLE with awready=wready=1 on the next cycle. Maximum throughput is one write per 3 cycles.
- Read FSM states: RD_IDLE (arready=1), RD_DATA (arready=0).
  - On the AR handshake, rdata/rresp are registered from the current register value; rvalid=1 on the next cycle.
  - Out-of-range -> rdata=0, rresp=SLVERR. RO registers read normally.
  - rdata, rresp and rvalid are held until rready. On handshake -> RD_IDLE.
- Channels are fully independent.
  - A read and a write commit to the same index in the same cycle: the read returns the pre-write value.
  - A read issued on any later cycle returns the new value.
- regs_o reflects register contents with no extra latency: updated on the commit edge.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_t and rd_state_t enums.
  - function addr_lsb(DATA_WIDTH).
- One natural sub-module, axi_lite_reg_array: NUM_REGS registers, strobe merge, RO mask, reset values and wr_pulse_o generation. It has a single write port (index, data, strobe, enable) and a parallel read-out. Both FSMs live in the top.

Test Plan:
Defaults DATA_WIDTH=32, NUM_REGS=16, RO_MASK=16'h0008, RESET_VAL reg3=32'hCAFE0001, others 0.
1. Reset, then read 0x00C -> rdata=32'hCAFE0001, rresp=OKAY; read 0x000 -> 0; all readies 1 and valids 0 after reset.
2. Write 0x004 data 32'h12345678 strb 4'b1111, AW and W in the same cycle -> wr_pulse_o[1] one cycle after handshake, bvalid the next cycle, bresp=OKAY, regs_o[63:32]=32'h12345678.
3. W first, AW 3 cycles later, then partial write strb 4'b0101 data 32'hAABBCCDD to 0x004 -> reg1=32'h12BB56DD; bready held low 5 cycles -> bvalid/bresp stable throughout.
4. Write to 0x00C (RO) and 0x040 (out-of-range) -> both bresp=SLVERR, reg3 unchanged, no wr_pulse_o bit; read 0x040 -> rdata=0, rresp=SLVERR.
5. Read 0x004 with the AR handshake on the cycle write to 0x004 data 32'h0 commits -> rdata = old value 32'h12BB56DD; a following read -> 32'h0.
6. Assert rst while bvalid=1 awaiting bready -> next cycle bvalid=0, awready=wready=1, all registers back to RESET_VAL.
